// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: job config, operand stream, MAC hookup and result stream bundle
interface mac_seq_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10,
  parameter int CNT_WIDTH  = 10
);
  logic                  cfg_start;
  logic [LEN_WIDTH-1:0]  cfg_len;
  logic [CNT_WIDTH-1:0]  cfg_count;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tlast;
  logic                  s_tready;
  logic                  mac_clr;
  logic                  mac_en;
  logic [DATA_WIDTH-1:0] mac_operand;
  logic [DATA_WIDTH-1:0] mac_acc;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;
  modport slave (
    input  cfg_start, cfg_len, cfg_count, s_tdata, s_tvalid, s_tlast, mac_acc, m_tready,
    output busy, done, error, s_tready, mac_clr, mac_en, mac_operand, m_tdata, m_tvalid, m_tlast
  );
  modport master (
    output cfg_start, cfg_len, cfg_count, s_tdata, s_tvalid, s_tlast, mac_acc, m_tready,
    input  busy, done, error, s_tready, mac_clr, mac_en, mac_operand, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer gating operand beats into a MAC and streaming one result per dot product
module mac_seq_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 10,
  parameter int CNT_WIDTH   = 10,
  parameter int MAC_LATENCY = 3
) (
  input logic            ACLK,
  input logic            ARESETN,
  mac_seq_ctrl_if.slave  bus
);
  localparam int LAT_W = $clog2(MAC_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, EMIT, DONE} state_t;
  state_t                state, state_nx;
  logic [LEN_WIDTH-1:0]  len_m1, tap_cnt;
  logic [CNT_WIDTH-1:0]  cnt_m1, out_cnt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [DATA_WIDTH-1:0] result;
  logic                  done_r, err_r;
  logic                  start_req, start_ok, beat, last_tap, out_last, emit_hs;
  always_comb begin
    start_req = state == IDLE && bus.cfg_start;
    start_ok  = start_req && bus.cfg_len != '0 && bus.cfg_count != '0;
    beat      = state == FEED && bus.s_tvalid;
    last_tap  = tap_cnt == len_m1;
    out_last  = out_cnt == cnt_m1;
    emit_hs   = state == EMIT && bus.m_tready;
    state_nx  = state;
    case (state)
      IDLE:    state_nx = start_ok ? CLEAR : IDLE;
      CLEAR:   state_nx = FEED;
      FEED:    state_nx = (beat && last_tap) ? DRAIN : FEED;
      DRAIN:   state_nx = (lat_cnt == '0) ? EMIT : DRAIN;
      EMIT:    state_nx = emit_hs ? (out_last ? DONE : CLEAR) : EMIT;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.busy        = state inside {CLEAR, FEED, DRAIN, EMIT};
  assign bus.done        = done_r;
  assign bus.error       = err_r;
  assign bus.s_tready    = state == FEED;
  assign bus.mac_clr     = state == CLEAR;
  assign bus.mac_en      = beat;
  assign bus.mac_operand = state == FEED ? bus.s_tdata : '0;
  assign bus.m_tdata     = result;
  assign bus.m_tvalid    = state == EMIT;
  assign bus.m_tlast     = state == EMIT && out_last;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      len_m1  <= '0;
      cnt_m1  <= '0;
      tap_cnt <= '0;
      out_cnt <= '0;
      lat_cnt <= '0;
      result  <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= (start_req && !start_ok) || (emit_hs && out_last);
      if (start_req)
        err_r <= !start_ok;
      else if (beat && bus.s_tlast != last_tap)
        err_r <= 1'b1;
      if (start_ok) begin
        len_m1  <= bus.cfg_len - 1'b1;
        cnt_m1  <= bus.cfg_count - 1'b1;
        out_cnt <= '0;
      end
      if (state == CLEAR)
        tap_cnt <= '0;
      else if (beat)
        tap_cnt <= tap_cnt + 1'b1;
      if (beat && last_tap)
        lat_cnt <= LAT_W'(MAC_LATENCY - 1);
      // the sum is only final once the MAC pipeline has fully drained
      if (state == DRAIN) begin
        if (lat_cnt == '0)
          result <= bus.mac_acc;
        else
          lat_cnt <= lat_cnt - 1'b1;
      end
      if (emit_hs && !out_last)
        out_cnt <= out_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed jobs against mac_seq_ctrl with a 3-cycle behavioural MAC
module tb_mac_seq_ctrl;
  localparam int DW = 32;
  logic ACLK = 1'b0;
  logic ARESETN;
  int n_chk = 0, n_fail = 0;
  int n_clr, n_en, n_done, busy_seen;
  logic [DW-1:0] res_q[$];
  logic          last_q[$];
  logic [DW-1:0] acc0, acc1, acc2;
  mac_seq_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(10), .CNT_WIDTH(10)) bus ();
  mac_seq_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(10), .CNT_WIDTH(10), .MAC_LATENCY(3)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus)
  );
  always #5 ACLK = ~ACLK;
  // accumulate stage plus two delay stages gives a 3-cycle MAC
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      acc0 <= '0;
      acc1 <= '0;
      acc2 <= '0;
    end else begin
      acc0 <= bus.mac_clr ? '0 : bus.mac_en ? acc0 + bus.mac_operand : acc0;
      acc1 <= acc0;
      acc2 <= acc1;
    end
  end
  assign bus.mac_acc = acc2;
  always @(negedge ACLK) begin
    if (bus.mac_clr) n_clr++;
    if (bus.mac_en) n_en++;
    if (bus.done) n_done++;
    if (bus.busy) busy_seen = 1;
    if (bus.m_tvalid && bus.m_tready) begin
      res_q.push_back(bus.m_tdata);
      last_q.push_back(bus.m_tlast);
    end
  end
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_mon();
    n_clr = 0;
    n_en = 0;
    n_done = 0;
    busy_seen = 0;
    res_q.delete();
    last_q.delete();
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask
  task automatic start(input int l, input int c);
    bus.cfg_start = 1'b1;
    bus.cfg_len   = 10'(l);
    bus.cfg_count = 10'(c);
    cyc(1);
    bus.cfg_start = 1'b0;
  endtask
  task automatic beat(input logic [DW-1:0] d, input logic l);
    int t = 0;
    logic ok;
    bus.s_tdata  = d;
    bus.s_tvalid = 1'b1;
    bus.s_tlast  = l;
    do begin
      @(negedge ACLK);
      ok = bus.s_tready;
      t++;
      cyc(1);
    end while (!ok && t < 50);
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask
  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 300) begin
      cyc(1);
      t++;
    end
    if (n_done < target) chk("done_timeout", n_done, target);
    cyc(3);
  endtask
  task automatic chk_res(input string tag, input int i, input logic [DW-1:0] d, input logic l);
    chk({tag, "_data"}, res_q.size() > i ? res_q[i] : 'x, d);
    chk({tag, "_last"}, res_q.size() > i ? 32'(last_q[i]) : 'x, 32'(l));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int t;
    ARESETN = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_len = '0;
    bus.cfg_count = '0;
    bus.s_tdata = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast = 1'b0;
    bus.m_tready = 1'b1;
    clear_mon();
    cyc(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    ARESETN = 1'b1;
    cyc(2);
    // basic two-output job
    clear_mon();
    start(4, 2);
    for (int i = 1; i <= 8; i++) beat(DW'(i), i % 4 == 0);
    wait_done(1);
    chk("t1_clr", n_clr, 2);
    chk("t1_en", n_en, 8);
    chk("t1_done", n_done, 1);
    chk("t1_nres", res_q.size(), 2);
    chk_res("t1_r0", 0, 10, 0);
    chk_res("t1_r1", 1, 26, 1);
    chk("t1_error", bus.error, 0);
    chk("t1_busy", bus.busy, 0);
    // output backpressure
    clear_mon();
    bus.m_tready = 1'b0;
    start(4, 2);
    for (int i = 0; i < 4; i++) beat(DW'(i + 2), i == 3);
    t = 0;
    while (!bus.m_tvalid && t < 20) begin
      cyc(1);
      t++;
    end
    chk("t2_latency", t, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t2_stall_tvalid", bus.m_tvalid, 1);
      chk("t2_stall_tdata", bus.m_tdata, 14);
      chk("t2_stall_tlast", bus.m_tlast, 0);
      chk("t2_stall_s_tready", bus.s_tready, 0);
      chk("t2_stall_mac_en", bus.mac_en, 0);
    end
    cyc(1);
    bus.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) beat(1, i == 3);
    wait_done(1);
    chk("t2_nres", res_q.size(), 2);
    chk_res("t2_r0", 0, 14, 0);
    chk_res("t2_r1", 1, 4, 1);
    chk("t2_en", n_en, 8);
    chk("t2_clr", n_clr, 2);
    // degenerate configurations
    clear_mon();
    start(0, 3);
    chk("t3a_done", bus.done, 1);
    chk("t3a_error", bus.error, 1);
    chk("t3a_busy", bus.busy, 0);
    cyc(1);
    chk("t3a_done_pulse", bus.done, 0);
    chk("t3a_error_sticky", bus.error, 1);
    start(3, 0);
    chk("t3b_done", bus.done, 1);
    chk("t3b_error", bus.error, 1);
    cyc(3);
    chk("t3_busy_seen", busy_seen, 0);
    chk("t3_clr", n_clr, 0);
    chk("t3_done_cycles", n_done, 2);
    // misplaced TLAST
    clear_mon();
    start(4, 2);
    chk("t4_error_cleared", bus.error, 0);
    for (int i = 1; i <= 4; i++) beat(DW'(i), i == 2);
    chk("t4_error_set", bus.error, 1);
    for (int i = 1; i <= 4; i++) beat(1, i == 4);
    wait_done(1);
    chk("t4_error_held", bus.error, 1);
    chk("t4_nres", res_q.size(), 2);
    chk_res("t4_r0", 0, 10, 0);
    chk_res("t4_r1", 1, 4, 1);
    // gapped beats and ignored start while busy
    clear_mon();
    start(3, 1);
    chk("t5_error_cleared", bus.error, 0);
    beat(7, 0);
    cyc(1);
    beat(8, 0);
    bus.cfg_start = 1'b1;
    bus.cfg_len = '0;
    cyc(1);
    bus.cfg_start = 1'b0;
    chk("t5_busy_kept", bus.busy, 1);
    cyc(1);
    beat(9, 1);
    wait_done(1);
    chk("t5_en", n_en, 3);
    chk("t5_nres", res_q.size(), 1);
    chk_res("t5_r0", 0, 24, 1);
    chk("t5_error", bus.error, 0);
    chk("t5_done", n_done, 1);
    // reset mid-FEED
    clear_mon();
    start(4, 1);
    beat(1, 1);
    beat(2, 0);
    chk("t6_pre_error", bus.error, 1);
    bus.s_tdata = 5;
    bus.s_tvalid = 1'b1;
    ARESETN = 1'b0;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_error", bus.error, 0);
    chk("t6_s_tready", bus.s_tready, 0);
    chk("t6_mac_clr", bus.mac_clr, 0);
    chk("t6_mac_en", bus.mac_en, 0);
    chk("t6_mac_operand", bus.mac_operand, 0);
    chk("t6_m_tvalid", bus.m_tvalid, 0);
    chk("t6_m_tlast", bus.m_tlast, 0);
    chk("t6_m_tdata", bus.m_tdata, 0);
    bus.s_tvalid = 1'b0;
    cyc(1);
    ARESETN = 1'b1;
    cyc(1);
    clear_mon();
    start(2, 1);
    beat(11, 0);
    beat(12, 1);
    wait_done(1);
    chk("t6_nres", res_q.size(), 1);
    chk_res("t6_r0", 0, 23, 1);
    chk("t6_en", n_en, 2);
    chk("t6_error_after", bus.error, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
